besthop_select: RTL and testbench
=================================

# besthop_select

Action-selection stage of the cluster-head Q-routing pipeline, directly upstream of the reward/packet-build stage. On `start` it scans the node's Q-value table in shared memory and finds the neighbour index with the highest Q-value. It then fetches that neighbour's node ID and presents `action` (winning index) and `besthop` (neighbour node ID) with a `done` pulse. The downstream stage consumes `action`/`besthop` and uses `done` as its start.

## Interface
Parameters:
- `WORD_WIDTH`, 16 — data/address width.
- `Q_BASE`, 16'h00C8 — byte address of Q-value table; entry i at `Q_BASE + 2*i`.
- `NB_BASE`, 16'h0048 — byte address of neighbour-ID table; entry i at `NB_BASE + 2*i`.
- `MAX_NEIGHBORS`, 64 — table capacity.

Ports:
- Reset `nreset`, synchronous, active-low; clock `clock`.
- `clock` in 1 — rising-edge clock.
- `nreset` in 1 — synchronous active-low reset.
- `start` in 1 — level; sampled only in IDLE.
- `nb_count` in 16 — number of valid neighbours; sampled with `start`.
- `data_in` in 16 — memory read data; valid one cycle after `address`.
- `address` out 16 — memory read byte address.
- `action` out 16 — winning neighbour index.
- `besthop` out 16 — node ID of winning neighbour.
- `done` out 1 — one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, DRAIN, FETCH, CAPT, DONE.
- IDLE: `address`=0. If `start`=1, latch `cnt = min(nb_count, MAX_NEIGHBORS)`, clear `idx`, `best_q`, `best_idx`, `have_best`. Go to SCAN if `cnt`>0; otherwise go to DONE with `action`=0 and `besthop`=16'hFFFF (no route).
- SCAN: `address = Q_BASE + 2*idx`; `idx++` each cycle. From the second SCAN cycle onward, compare `data_in` (Q of `idx-1`).
- SCAN leaves for DRAIN after issuing `idx = cnt-1`.
- DRAIN: compare the final entry; `address` = 0.
- FETCH: `address = NB_BASE + 2*best_idx`.
- CAPT: `besthop <= data_in`; `action <= best_idx`.
- DONE: `done`=1 for exactly one cycle, then IDLE. `action`/`besthop` hold until the next completion or reset.
- Compare rule: the first entry read always loads `best_q`/`best_idx`. After that, update only if `data_in > best_q`, unsigned strict. Ties keep the lowest index.
- Arithmetic: address sums are 16-bit modulo 2^16. `idx` is wide enough for `MAX_NEIGHBORS`.
- `start` while not IDLE is ignored. `start` held high after DONE re-triggers a new scan from IDLE.
- `nb_count` changes mid-scan have no effect.

## Timing
- Memory: synchronous read, 1-cycle latency. Data for the address driven in cycle t is valid on `data_in` in cycle t+1.
- `address` is combinational from state/`idx`/`best_idx`. Glitch-free relative to the clock edge is sufficient.
- Latency, with cycle 1 = first SCAN cycle (the cycle after the edge that samples `start`):
  - N neighbours: SCAN cycles 1..N, DRAIN N+1, FETCH N+2, CAPT N+3, `done` in cycle N+4.
  - N=0: `done` in the cycle after `start` is sampled.
- Reset values: `address`=0, `action`=0, `besthop`=0, `done`=0, state IDLE.
- Reset mid-operation aborts the scan the next edge, with no `done`.

## Structure
- Shared package `rl_route_pkg`:
  - `WORD_WIDTH`.
  - Memory-map constants for the neighbour-ID table (0x048), Q table (0x0C8), cluster table (0x148) and hop-value table (0x1C8).
  - `MAX_NEIGHBORS`.
  - `NO_ROUTE` = 16'hFFFF.
  - State enum.
- One natural sub-module: `argmax_tracker`, holding the running max/index with first-load and strict-greater rules. The FSM and address generation stay in `besthop_select`.

## Test plan
- N=4, Q={10,40,25,40}, NB={0x11,0x22,0x33,0x44} -> `action`=1, `besthop`=0x22, `done` in cycle 8. Addresses seen: C8,CA,CC,CE,0,4A.
- N=1, Q={0}, NB={0x07} -> `action`=0, `besthop`=0x07, `done` in cycle 5.
- N=0 -> `action`=0, `besthop`=0xFFFF, `done` the cycle after `start`; no memory reads.
- N=200 (clamped to 64), max Q=0xFFFF at index 63 -> last Q address 0x146, `action`=63, NB fetch at 0xC6.
- Reset asserted in SCAN cycle 3 of an N=8 scan -> all outputs 0, no `done`. A subsequent `start` completes normally.
- `start` toggled during the scan and held high after DONE -> the mid-scan toggle is ignored, and a second scan begins immediately with identical results.

Source files
------------

// File: rtl/rl_route_pkg.sv
// Shared definitions for the cluster-head Q-routing pipeline: memory map,
// table sizing and the action-selection state encoding.
package rl_route_pkg;

    localparam int WORD_WIDTH    = 16;
    localparam int MAX_NEIGHBORS = 64;

    // Byte addresses of the per-node tables in shared memory.
    localparam logic [15:0] NB_TABLE_BASE      = 16'h0048;
    localparam logic [15:0] Q_TABLE_BASE       = 16'h00C8;
    localparam logic [15:0] CLUSTER_TABLE_BASE = 16'h0148;
    localparam logic [15:0] HOP_TABLE_BASE     = 16'h01C8;

    localparam logic [15:0] NO_ROUTE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FETCH = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running maximum over a stream of samples: the first sample always loads,
// later ones replace the best only when strictly greater (ties keep lowest index).
module argmax_tracker #(
    parameter int WORD_WIDTH = 16,
    parameter int IDX_W      = 7
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  clear,
    input  logic                  sample,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [IDX_W-1:0]      index,
    output logic [IDX_W-1:0]      best_idx
);

    logic [WORD_WIDTH-1:0] best_q;
    logic                  have_best;

    always_ff @(posedge clock) begin
        if (!nreset || clear) begin
            best_q    <= '0;
            best_idx  <= '0;
            have_best <= 1'b0;
        end else if (sample && (!have_best || data > best_q)) begin
            best_q    <= data;
            best_idx  <= index;
            have_best <= 1'b1;
        end
    end

endmodule

// File: rtl/besthop_select.sv
// Action selection: scans the Q table for the neighbour with the highest Q,
// then fetches that neighbour's node ID and pulses done.
module besthop_select
    import rl_route_pkg::*;
#(
    parameter int               WORD_WIDTH    = rl_route_pkg::WORD_WIDTH,
    parameter logic [15:0]      Q_BASE        = rl_route_pkg::Q_TABLE_BASE,
    parameter logic [15:0]      NB_BASE       = rl_route_pkg::NB_TABLE_BASE,
    parameter int               MAX_NEIGHBORS = rl_route_pkg::MAX_NEIGHBORS
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] nb_count,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] action,
    output logic [WORD_WIDTH-1:0] besthop,
    output logic                  done
);

    localparam int IDX_W = $clog2(MAX_NEIGHBORS + 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] start_cnt;
    logic [IDX_W-1:0] best_idx;
    logic             track_clear;
    logic             track_sample;

    always_comb begin
        start_cnt = nb_count[IDX_W-1:0];
        if (nb_count > WORD_WIDTH'(MAX_NEIGHBORS)) begin
            start_cnt = IDX_W'(MAX_NEIGHBORS);
        end
    end

    // Read data lags the address by one cycle, so a SCAN cycle compares the
    // entry issued in the previous cycle and DRAIN compares the last one.
    assign track_clear  = (state == ST_IDLE) && start;
    assign track_sample = ((state == ST_SCAN) && (idx != '0)) || (state == ST_DRAIN);

    argmax_tracker #(
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (IDX_W)
    ) u_tracker (
        .clock    (clock),
        .nreset   (nreset),
        .clear    (track_clear),
        .sample   (track_sample),
        .data     (data_in),
        .index    (idx - IDX_W'(1)),
        .best_idx (best_idx)
    );

    always_comb begin
        state_next = state;
        address    = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (start_cnt != '0) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                address = Q_BASE + WORD_WIDTH'({idx, 1'b0});
                if (idx == cnt - IDX_W'(1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                address    = NB_BASE + WORD_WIDTH'({best_idx, 1'b0});
                state_next = ST_CAPT;
            end
            ST_CAPT: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign done = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cnt     <= '0;
            action  <= '0;
            besthop <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt <= start_cnt;
                        idx <= '0;
                        if (start_cnt == '0) begin
                            action  <= '0;
                            besthop <= NO_ROUTE;
                        end
                    end
                end
                ST_SCAN: begin
                    idx <= idx + IDX_W'(1);
                end
                ST_CAPT: begin
                    besthop <= data_in;
                    action  <= WORD_WIDTH'(best_idx);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_besthop_select.sv
// Bench for besthop_select: table-driven and random scans against a memory
// model, with a scoreboard of expected {action, besthop} results.
module tb_besthop_select;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start;
    logic [15:0] nb_count;
    logic [15:0] data_in;
    logic [15:0] address;
    logic [15:0] action;
    logic [15:0] besthop;
    logic        done;

    always #5 clock = ~clock;

    besthop_select dut (
        .clock    (clock),
        .nreset   (nreset),
        .start    (start),
        .nb_count (nb_count),
        .data_in  (data_in),
        .address  (address),
        .action   (action),
        .besthop  (besthop),
        .done     (done)
    );

    logic [15:0] mem [0:255];
    logic [15:0] qv  [0:63];
    logic [15:0] nbv [0:63];

    always @(posedge clock) data_in <= mem[address[8:1]];

    int pass_count  = 0;
    int check_count = 0;

    logic [31:0] exp_q[$];
    logic [15:0] addr_log[$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    task automatic load_tables();
        for (int i = 0; i < 64; i++) begin
            mem[100 + i] = qv[i];
            mem[36 + i]  = nbv[i];
        end
    endtask

    function automatic logic [31:0] model(input int n);
        int          cnt;
        int          bi;
        logic [15:0] bq;
        cnt = (n > 64) ? 64 : n;
        if (cnt == 0) return {16'h0000, 16'hFFFF};
        bi = 0;
        bq = qv[0];
        for (int i = 1; i < cnt; i++) begin
            if (qv[i] > bq) begin
                bq = qv[i];
                bi = i;
            end
        end
        return {16'(bi), nbv[bi]};
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (nreset && done) begin
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("result", {action, besthop}, exp_q.pop_front());
        end
    end

    task automatic run_scan(input int n, input bit toggle, output int done_cyc);
        exp_q.push_back(model(n));
        addr_log.delete();
        @(negedge clock);
        start    = 1'b1;
        nb_count = 16'(n);
        @(posedge clock);
        #1;
        start    = 1'b0;
        nb_count = 16'($urandom_range(0, 65535));
        done_cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clock);
            addr_log.push_back(address);
            if (toggle && c == 2) start = 1'b1;
            if (toggle && c == 3) start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_test1_tables();
        for (int i = 0; i < 64; i++) begin
            qv[i]  = 16'h0;
            nbv[i] = 16'h0;
        end
        qv[0] = 16'd10; qv[1] = 16'd40; qv[2] = 16'd25; qv[3] = 16'd40;
        nbv[0] = 16'h11; nbv[1] = 16'h22; nbv[2] = 16'h33; nbv[3] = 16'h44;
        load_tables();
    endtask

    initial begin
        int          dc;
        int          dones;
        int          first_c;
        int          second_c;
        int          n;
        logic [15:0] ea [0:5];

        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        nreset   = 1'b0;
        start    = 1'b0;
        nb_count = 16'h0;
        repeat (3) @(negedge clock);
        check("reset_address", 32'(address), 32'h0);
        check("reset_action", 32'(action), 32'h0);
        check("reset_besthop", 32'(besthop), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        nreset = 1'b1;
        @(negedge clock);
        check("idle_address", 32'(address), 32'h0);

        // Ties between indices 1 and 3 resolve to the lower index.
        set_test1_tables();
        run_scan(4, 1'b0, dc);
        check("n4_latency", 32'(dc), 32'd8);
        ea[0] = 16'h00C8; ea[1] = 16'h00CA; ea[2] = 16'h00CC;
        ea[3] = 16'h00CE; ea[4] = 16'h0000; ea[5] = 16'h004A;
        for (int i = 0; i < 6; i++) begin
            if (addr_log.size() > i) check($sformatf("n4_addr%0d", i), 32'(addr_log[i]), 32'(ea[i]));
            else check($sformatf("n4_addr%0d_missing", i), 32'd0, 32'd1);
        end

        // Single neighbour with Q=0 still wins by the first-load rule.
        for (int i = 0; i < 64; i++) begin qv[i] = 16'h5; nbv[i] = 16'h99; end
        qv[0] = 16'h0; nbv[0] = 16'h07;
        load_tables();
        run_scan(1, 1'b0, dc);
        check("n1_latency", 32'(dc), 32'd5);
        if (addr_log.size() >= 3) begin
            check("n1_addr_q", 32'(addr_log[0]), 32'h00C8);
            check("n1_addr_nb", 32'(addr_log[2]), 32'h0048);
        end else check("n1_addr_missing", 32'd0, 32'd1);

        run_scan(0, 1'b0, dc);
        check("n0_latency", 32'(dc), 32'd1);
        if (addr_log.size() >= 1) check("n0_no_read", 32'(addr_log[0]), 32'h0);

        // Count clamps to the table capacity; the maximum sits in the last slot.
        for (int i = 0; i < 63; i++) begin qv[i] = 16'(i * 3); nbv[i] = 16'(16'h100 + i); end
        qv[63] = 16'hFFFF; nbv[63] = 16'h013F;
        load_tables();
        run_scan(200, 1'b0, dc);
        check("n200_latency", 32'(dc), 32'd68);
        if (addr_log.size() >= 66) begin
            check("n200_last_q_addr", 32'(addr_log[63]), 32'h0146);
            check("n200_drain_addr", 32'(addr_log[64]), 32'h0);
            check("n200_nb_addr", 32'(addr_log[65]), 32'h00C6);
        end else check("n200_addr_missing", 32'd0, 32'd1);

        // Reset in the third SCAN cycle of an 8-entry scan.
        for (int i = 0; i < 64; i++) begin
            qv[i]  = 16'($urandom_range(0, 1000));
            nbv[i] = 16'($urandom_range(0, 65535));
        end
        load_tables();
        @(negedge clock);
        start    = 1'b1;
        nb_count = 16'd8;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_in_scan_addr", 32'(address), 32'h00CA);
        nreset = 1'b0;
        @(negedge clock);
        check("abort_address", 32'(address), 32'h0);
        check("abort_action", 32'(action), 32'h0);
        check("abort_besthop", 32'(besthop), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(negedge clock);
        nreset = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_scan(8, 1'b0, dc);
        check("after_abort_latency", 32'(dc), 32'd12);

        // Mid-scan start toggle is ignored; start held through DONE re-triggers.
        set_test1_tables();
        run_scan(4, 1'b1, dc);
        check("toggle_latency", 32'(dc), 32'd8);
        exp_q.push_back(model(4));
        exp_q.push_back(model(4));
        @(negedge clock);
        start    = 1'b1;
        nb_count = 16'd4;
        dones    = 0;
        first_c  = 0;
        second_c = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                if (dones == 1) first_c = c;
                else begin
                    second_c = c;
                    start    = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_first_done", 32'(first_c), 32'd8);
        check("held_second_done", 32'(second_c), 32'd17);

        // Random tables with a narrow Q range so ties are common.
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < 64; i++) begin
                qv[i]  = 16'($urandom_range(0, 7));
                nbv[i] = 16'($urandom_range(0, 65535));
            end
            load_tables();
            run_scan(n, 1'b0, dc);
            check($sformatf("rand%0d_latency", t), 32'(dc), 32'(n + 4));
        end

        repeat (4) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
